// File: rtl/icache_if.sv
// icache_if: fetch-port bundle between the datapath, the icache and the
// memory controller's instruction port.
//   imemREN/imemaddr  datapath fetch request and word address
//   ihit/imemload     fetch satisfied this cycle / instruction word
//   iREN/iaddr        single-word read request to memory
//   iwait/iload       memory busy / read data
// slave  : the cache's view (responder to the datapath, requester to memory)
// master : the combined datapath + memory view driving the cache
interface icache_if #(
   parameter int ADDR_W = 32
);
   logic              imemREN;
   logic [ADDR_W-1:0] imemaddr;
   logic              ihit;
   logic [ADDR_W-1:0] imemload;
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              iwait;
   logic [ADDR_W-1:0] iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits return combinationally in the request cycle; a miss issues a single
// word read, refills the frame, then the lookup hits on the following cycle.
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (clears valid bits, FSM, counters)
//   dcif       icache_if.slave fetch/memory bundle
//   hit_count  cycles with ihit=1        (only with ICACHE_STATS_EN)
//   miss_count IDLE->FETCH transitions   (only with ICACHE_STATS_EN)
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss counters.
module icache #(
   parameter int SETS   = 16,
   parameter int ADDR_W = 32
) (
   input  logic        CLK,
   input  logic        RST,
   icache_if.slave     dcif
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t state, next_state;

   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag_arr  [SETS];
   logic [ADDR_W-1:0] data_arr [SETS];
   logic [ADDR_W-1:0] miss_addr;

   logic [IDX_W-1:0]  req_idx, miss_idx;
   logic [TAG_W-1:0]  req_tag, miss_tag;
   logic              lookup_hit;
   logic              start_miss;
   logic              refill;

   always_comb begin
      req_idx    = dcif.imemaddr[IDX_W+1:2];
      req_tag    = dcif.imemaddr[ADDR_W-1:IDX_W+2];
      miss_idx   = miss_addr[IDX_W+1:2];
      miss_tag   = miss_addr[ADDR_W-1:IDX_W+2];
      lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state    = state;
      dcif.ihit     = 1'b0;
      dcif.imemload = '0;
      dcif.iREN     = 1'b0;
      dcif.iaddr    = '0;
      start_miss    = 1'b0;
      refill        = 1'b0;
      case (state)
         IDLE: begin
            if (dcif.imemREN) begin
               if (lookup_hit) begin
                  dcif.ihit     = 1'b1;
                  dcif.imemload = data_arr[req_idx];
               end else begin
                  start_miss = 1'b1;
                  next_state = FETCH;
               end
            end
         end
         FETCH: begin
            // The read is not cancellable: imemREN/imemaddr are ignored here.
            dcif.iREN  = 1'b1;
            dcif.iaddr = miss_addr;
            if (!dcif.iwait) begin
               refill     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid     <= '0;
         miss_addr <= '0;
      end else begin
         if (start_miss) miss_addr <= dcif.imemaddr;
         if (refill)     valid[miss_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; a refill cut short by RST is dropped.
   always_ff @(posedge CLK) begin
      if (!RST && refill) begin
         tag_arr[miss_idx]  <= miss_tag;
         data_arr[miss_idx] <= dcif.iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (dcif.ihit) hit_count  <= hit_count + 32'd1;
         if (start_miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. Stimulus pushes expected memory
// read addresses and expected hit data into queues; a negedge monitor pops
// and compares whenever the cache completes a memory read or asserts ihit.
module tb_icache;

   localparam int ADDR_W = 32;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   icache_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache #(.SETS(16), .ADDR_W(ADDR_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .dcif       (bus.slave)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int exp_hits = 0;
   int exp_misses = 0;
   logic [31:0] exp_req_q [$];
   logic [31:0] exp_hit_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Monitor: consumes the scoreboard on DUT-presented events.
   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.ihit) begin
            if (exp_hit_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hit actual=ihit=1 addr=0x%08h required=no pending fetch", bus.imemaddr);
            end else begin
               check("hit_imemload", bus.imemload, exp_hit_q.pop_front());
            end
         end
         if (bus.iREN && !bus.iwait) begin
            if (exp_req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read actual=iaddr=0x%08h required=no pending read", bus.iaddr);
            end else begin
               check("read_iaddr", bus.iaddr, exp_req_q.pop_front());
            end
         end
      end
   end

   // Holds a fetch until ihit; memory stalls nwait FETCH cycles before completing.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                           input int nwait, input bit miss, input string name);
      int ren = 0;
      bit got = 1'b0;
      logic ren_at_hit = 1'b0;
      if (miss) begin
         exp_req_q.push_back(addr);
         exp_misses++;
      end
      exp_hit_q.push_back(data);
      exp_hits++;
      bus.imemREN  = 1'b1;
      bus.imemaddr = addr;
      bus.iload    = data;
      bus.iwait    = (nwait > 0);
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (bus.ihit) begin
            got = 1'b1;
            ren_at_hit = bus.iREN;
            break;
         end
         if (bus.iREN) ren++;
         @(posedge CLK); #1;
         bus.iwait = (ren < nwait);
      end
      check({name, "_hit_seen"}, 32'(got), 32'd1);
      check({name, "_iREN_cycles"}, 32'(ren), miss ? 32'(nwait + 1) : 32'd0);
      check({name, "_iREN_at_hit"}, 32'(ren_at_hit), 32'd0);
      @(posedge CLK); #1;
      bus.imemREN = 1'b0;
      bus.iwait   = 1'b1;
   endtask

   initial begin
      bit got;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Reset state
      @(negedge CLK);
      check("rst_ihit", 32'(bus.ihit), 32'd0);
      check("rst_imemload", bus.imemload, 32'd0);
      check("rst_iREN", 32'(bus.iREN), 32'd0);
      check("rst_iaddr", bus.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
`endif
      @(posedge CLK); #1;

      // Cold fetch with two wait states, then repeat hit
      do_fetch(32'h00, 32'h2001000A, 2, 1'b1, "cold");
      do_fetch(32'h00, 32'h2001000A, 0, 1'b0, "repeat");
`ifdef ICACHE_STATS_EN
      check("repeat_hit_count", hit_count, 32'(exp_hits));
      check("repeat_miss_count", miss_count, 32'd1);
`endif

      // Conflict on index 0
      do_fetch(32'h40, 32'h11110040, 0, 1'b1, "conflict_new");
      do_fetch(32'h00, 32'h2001000A, 0, 1'b1, "conflict_old");

      // Address change mid-miss: refill of 0x04 completes, then 0x08 misses
      exp_req_q.push_back(32'h04);
      exp_misses++;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h04;
      bus.iwait    = 1'b1;
      bus.iload    = 32'hD0000004;
      @(negedge CLK);
      check("midmiss_detect_ihit", 32'(bus.ihit), 32'd0);
      @(posedge CLK); #1;
      bus.imemaddr = 32'h08;
      @(negedge CLK);
      check("midmiss_iREN", 32'(bus.iREN), 32'd1);
      check("midmiss_iaddr", bus.iaddr, 32'h04);
      @(posedge CLK); #1;
      bus.iwait = 1'b0;
      @(negedge CLK);
      check("midmiss_done_iaddr", bus.iaddr, 32'h04);
      @(posedge CLK); #1;
      bus.iwait = 1'b1;
      bus.iload = 32'hD0000008;
      @(negedge CLK);
      check("midmiss_next_ihit", 32'(bus.ihit), 32'd0);
      check("midmiss_next_iREN", 32'(bus.iREN), 32'd0);
      check("midmiss_next_imemload", bus.imemload, 32'd0);
      exp_req_q.push_back(32'h08);
      exp_hit_q.push_back(32'hD0000008);
      exp_misses++;
      exp_hits++;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK); #1;
         bus.iwait = 1'b0;
         @(negedge CLK);
         if (bus.ihit) begin
            got = 1'b1;
            break;
         end
      end
      check("midmiss_08_hit_seen", 32'(got), 32'd1);
      @(posedge CLK); #1;
      bus.imemREN = 1'b0;
      bus.iwait   = 1'b1;
      do_fetch(32'h04, 32'hD0000004, 0, 1'b0, "midmiss_04_reuse");

      // Reset during FETCH with iwait=1
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h10;
      bus.iwait    = 1'b1;
      bus.iload    = 32'hDEAD0010;
      @(negedge CLK);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("rstfetch_iREN_before", 32'(bus.iREN), 32'd1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      bus.imemREN = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
      @(negedge CLK);
      check("rstfetch_iREN_after", 32'(bus.iREN), 32'd0);
      check("rstfetch_iaddr_after", bus.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
      check("rstfetch_hit_count", hit_count, 32'd0);
      check("rstfetch_miss_count", miss_count, 32'd0);
`endif
      @(posedge CLK); #1;
      do_fetch(32'h04, 32'h0BADF00D, 0, 1'b1, "post_reset_04");

      // Idle
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         check("idle_ihit", 32'(bus.ihit), 32'd0);
         check("idle_iREN", 32'(bus.iREN), 32'd0);
      end
`ifdef ICACHE_STATS_EN
      check("idle_hit_count", hit_count, 32'(exp_hits));
      check("idle_miss_count", miss_count, 32'(exp_misses));
`endif

      check("hit_queue_drained", 32'(exp_hit_q.size()), 32'd0);
      check("read_queue_drained", 32'(exp_req_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
